stage_fetch0: RTL and testbench
===============================

// Module: stage_fetch0
// PURPOSE
//  First fetch stage: owns the architectural fetch PC, drives the synchronous-read imem address,
//  and predicts taken branches with a direct-mapped BTB plus 2-bit saturating counters.
//  Feeds pcF0/pcPlus4F0/bPredictedTakenF into the fetch-1 pipeline register; imem data returns next cycle.
//  Accepts redirects and branch-resolution updates from execute.
// PARAMETERS
//  RESET_PC     32'h0000_0000  fetch PC after reset
//  BTB_ENTRIES  16             BTB depth, power of 2 >= 2; IDX_W = $clog2(BTB_ENTRIES)
// PORTS
//  clk               in   1   clock, all state on posedge
//  rst               in   1   synchronous active-high reset
//  stall             in   1   hold PC (downstream stalled)
//  redirectValid     in   1   execute mispredict/jump: restart fetch at redirectPc
//  redirectPc        in   32  restart address, word aligned
//  bUpdateValid      in   1   resolved branch/jump update for BTB
//  bUpdatePc         in   32  PC of resolved branch
//  bUpdateTaken      in   1   actual direction
//  bUpdateTarget     in   32  actual target (valid when taken)
//  imemAddr          out  32  instruction memory read address (= pcF0)
//  pcF0              out  32  current fetch PC
//  pcPlus4F0         out  32  pcF0 + 4
//  bPredictedTakenF  out  1   BTB predicts pcF0 is a taken branch
// BEHAVIOUR
//  Interface: one clock clk; reset rst is synchronous, active-high.
//  Reset: pc <= RESET_PC; all BTB valid bits <= 0, counters <= 2'b01. Outputs after reset:
//   pcF0=RESET_PC, pcPlus4F0=RESET_PC+4, imemAddr=RESET_PC, bPredictedTakenF=0. rst overrides all inputs.
//  Datapath: imemAddr, pcF0, pcPlus4F0 combinational from pc register; +4 wraps mod 2^32.
//  BTB entry: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]; index = pc[IDX_W+1:2]; pc[1:0] ignored.
//  Lookup (combinational, same cycle): hit = valid & tag match; bPredictedTakenF = hit & ctr[1].
//  Next PC priority (registered on posedge):
//   1. redirectValid      -> redirectPc (wins over stall)
//   2. stall              -> hold pc
//   3. bPredictedTakenF   -> entry target
//   4. else               -> pc + 4
//  BTB update (when bUpdateValid, registered, effective next cycle):
//   hit & taken      -> ctr = sat_inc(ctr), target <= bUpdateTarget
//   hit & not taken  -> ctr = sat_dec(ctr), target unchanged; ctr saturates at 00 / 11
//   miss & taken     -> allocate: valid=1, new tag, target, ctr=2'b10 (replace any aliased entry)
//   miss & not taken -> no change
//  Update and lookup on same index in same cycle: lookup sees pre-update contents.
//  Updates proceed regardless of stall/redirect. Single write port, no bypass.
//  No internal FSM beyond pc reg + BTB array; no valid/flush output (bubble handling is fetch-1's job).
// TESTING
//  T1 reset, no stall/redirect, 4 cycles -> pcF0 = 0x0,0x4,0x8,0xC; bPredictedTakenF=0 throughout.
//  T2 update pc=0x10 taken target=0x40; later fetch reaches 0x10 -> bPredictedTakenF=1, next pcF0=0x40.
//  T3 after T2, two not-taken updates for 0x10 (ctr 10->01->00) -> at 0x10 predict 0, next pcF0=0x14.
//  T4 alias: 0x50 shares index 4 with 0x10 (BTB_ENTRIES=16) -> fetch 0x50 gives bPredictedTakenF=0;
//     not-taken miss update for 0x90 leaves 0x10 entry intact.
//  T5 stall=1 and redirectValid=1, redirectPc=0x200 same cycle -> next pcF0=0x200; stall alone holds pcF0.
//  T6 rst asserted mid-run with pending bUpdateValid -> next cycle pcF0=RESET_PC, BTB empty (no predictions).

Source files
------------

// File: rtl/stage_fetch0.sv
// First fetch stage: owns the fetch PC, drives the synchronous imem address and
// predicts taken branches with a direct-mapped BTB holding 2-bit saturating counters.
module stage_fetch0 #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirectValid,
    input  logic [31:0] redirectPc,
    input  logic        bUpdateValid,
    input  logic [31:0] bUpdatePc,
    input  logic        bUpdateTaken,
    input  logic [31:0] bUpdateTarget,
    output logic [31:0] imemAddr,
    output logic [31:0] pcF0,
    output logic [31:0] pcPlus4F0,
    output logic        bPredictedTakenF
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [31:0]      r_pc;
    logic             r_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] r_tag    [BTB_ENTRIES];
    logic [31:0]      r_target [BTB_ENTRIES];
    logic [1:0]       r_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lookIdx;
    logic [TAG_W-1:0] w_lookTag;
    logic             w_lookHit;
    logic             w_predTaken;
    logic [31:0]      w_pcPlus4;
    logic [31:0]      w_nextPc;
    logic [IDX_W-1:0] w_updIdx;
    logic [TAG_W-1:0] w_updTag;
    logic             w_updHit;
    logic [1:0]       w_updCtr;

    assign w_pcPlus4   = r_pc + 32'd4;
    assign w_lookIdx   = r_pc[IDX_W+1:2];
    assign w_lookTag   = r_pc[31:IDX_W+2];
    assign w_lookHit   = r_valid[w_lookIdx] && (r_tag[w_lookIdx] == w_lookTag);
    assign w_predTaken = w_lookHit && r_ctr[w_lookIdx][1];

    assign imemAddr         = r_pc;
    assign pcF0             = r_pc;
    assign pcPlus4F0        = w_pcPlus4;
    assign bPredictedTakenF = w_predTaken;

    assign w_updIdx = bUpdatePc[IDX_W+1:2];
    assign w_updTag = bUpdatePc[31:IDX_W+2];
    assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

    // Redirect beats stall; a prediction only steers an un-stalled fetch.
    always_comb begin
        w_nextPc = w_pcPlus4;
        if (redirectValid) begin
            w_nextPc = redirectPc;
        end else if (stall) begin
            w_nextPc = r_pc;
        end else if (w_predTaken) begin
            w_nextPc = r_target[w_lookIdx];
        end
    end

    always_comb begin
        w_updCtr = r_ctr[w_updIdx];
        if (bUpdateTaken) begin
            if (r_ctr[w_updIdx] != 2'b11) begin
                w_updCtr = r_ctr[w_updIdx] + 2'd1;
            end
        end else begin
            if (r_ctr[w_updIdx] != 2'b00) begin
                w_updCtr = r_ctr[w_updIdx] - 2'd1;
            end
        end
    end

    // A taken miss overwrites whatever entry aliases to the same index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else begin
            r_pc <= w_nextPc;
            if (bUpdateValid) begin
                if (w_updHit) begin
                    r_ctr[w_updIdx] <= w_updCtr;
                    if (bUpdateTaken) begin
                        r_target[w_updIdx] <= bUpdateTarget;
                    end
                end else if (bUpdateTaken) begin
                    r_valid[w_updIdx]  <= 1'b1;
                    r_tag[w_updIdx]    <= w_updTag;
                    r_target[w_updIdx] <= bUpdateTarget;
                    r_ctr[w_updIdx]    <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_stage_fetch0.sv
// Directed and randomized bench for stage_fetch0, checked against a behavioural
// model of the fetch PC and BTB kept as plain arrays.
module tb_stage_fetch0;

    localparam int N = 16;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        bUpdateValid;
    logic [31:0] bUpdatePc;
    logic        bUpdateTaken;
    logic [31:0] bUpdateTarget;
    logic [31:0] imemAddr;
    logic [31:0] pcF0;
    logic [31:0] pcPlus4F0;
    logic        bPredictedTakenF;

    int testCount = 0;
    int failCount = 0;

    // Reference state: PC plus one record per BTB slot.
    logic [31:0] mPc;
    bit          mValid  [N];
    int unsigned mTag    [N];
    logic [31:0] mTarget [N];
    int          mCtr    [N];

    stage_fetch0 #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(N)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirectValid(redirectValid),
        .redirectPc(redirectPc),
        .bUpdateValid(bUpdateValid),
        .bUpdatePc(bUpdatePc),
        .bUpdateTaken(bUpdateTaken),
        .bUpdateTarget(bUpdateTarget),
        .imemAddr(imemAddr),
        .pcF0(pcF0),
        .pcPlus4F0(pcPlus4F0),
        .bPredictedTakenF(bPredictedTakenF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int slotOf(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic bit modelPredict(input logic [31:0] pc);
        int s = slotOf(pc);
        return mValid[s] && (mTag[s] == tagOf(pc)) && (mCtr[s] >= 2);
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic modelStep();
        logic [31:0] nextPc;
        int s;
        if (rst) begin
            mPc = 32'h0;
            for (int i = 0; i < N; i++) begin
                mValid[i] = 0;
                mCtr[i]   = 1;
            end
            return;
        end
        if (redirectValid)          nextPc = redirectPc;
        else if (stall)             nextPc = mPc;
        else if (modelPredict(mPc)) nextPc = mTarget[slotOf(mPc)];
        else                        nextPc = mPc + 32'd4;
        if (bUpdateValid) begin
            s = slotOf(bUpdatePc);
            if (mValid[s] && mTag[s] == tagOf(bUpdatePc)) begin
                if (bUpdateTaken) begin
                    mCtr[s]    = (mCtr[s] < 3) ? mCtr[s] + 1 : 3;
                    mTarget[s] = bUpdateTarget;
                end else begin
                    mCtr[s] = (mCtr[s] > 0) ? mCtr[s] - 1 : 0;
                end
            end else if (bUpdateTaken) begin
                mValid[s]  = 1;
                mTag[s]    = tagOf(bUpdatePc);
                mTarget[s] = bUpdateTarget;
                mCtr[s]    = 2;
            end
        end
        mPc = nextPc;
    endtask

    // Check outputs against the model mid-cycle, then clock once.
    task automatic applyStimulus();
        @(negedge clk);
        checkOutput("pcF0", pcF0, mPc);
        checkOutput("imemAddr", imemAddr, mPc);
        checkOutput("pcPlus4F0", pcPlus4F0, mPc + 32'd4);
        checkOutput("bPredictedTakenF", {31'd0, bPredictedTakenF}, {31'd0, modelPredict(mPc)});
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic clearInputs();
        rst           = 1'b0;
        stall         = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;
        bUpdateValid  = 1'b0;
        bUpdatePc     = 32'h0;
        bUpdateTaken  = 1'b0;
        bUpdateTarget = 32'h0;
    endtask

    task automatic setUpdate(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        bUpdateValid  = 1'b1;
        bUpdatePc     = pc;
        bUpdateTaken  = taken;
        bUpdateTarget = target;
    endtask

    task automatic expectFetch(input string tag, input logic [31:0] pc, input logic pred);
        checkOutput({tag, " pc"}, pcF0, pc);
        checkOutput({tag, " pred"}, {31'd0, bPredictedTakenF}, {31'd0, pred});
    endtask

    initial begin
        clearInputs();
        mPc = 32'h0;

        rst = 1'b1;
        @(posedge clk);
        modelStep();
        #1;
        rst = 1'b0;

        // T1: sequential fetch from reset
        expectFetch("T1 reset", 32'h0, 1'b0);
        checkOutput("T1 pcPlus4", pcPlus4F0, 32'h4);
        checkOutput("T1 imemAddr", imemAddr, 32'h0);
        applyStimulus(); expectFetch("T1 c1", 32'h4, 1'b0);
        applyStimulus(); expectFetch("T1 c2", 32'h8, 1'b0);

        // T2: train 0x10 taken -> 0x40
        setUpdate(32'h10, 1'b1, 32'h40);
        applyStimulus(); expectFetch("T2 c3", 32'hC, 1'b0);
        clearInputs();
        applyStimulus(); expectFetch("T2 hit", 32'h10, 1'b1);
        applyStimulus(); expectFetch("T2 target", 32'h40, 1'b0);

        // T3: two not-taken updates drop prediction
        setUpdate(32'h10, 1'b0, 32'h0);
        applyStimulus();
        applyStimulus();
        clearInputs();
        redirectValid = 1'b1; redirectPc = 32'h10;
        applyStimulus();
        clearInputs();
        expectFetch("T3 at10", 32'h10, 1'b0);
        applyStimulus(); expectFetch("T3 fall", 32'h14, 1'b0);

        // T4: retrain 0x10, then check aliasing addresses leave it alone
        setUpdate(32'h10, 1'b1, 32'h40);
        applyStimulus();
        applyStimulus();
        clearInputs();
        redirectValid = 1'b1; redirectPc = 32'h50;
        applyStimulus();
        clearInputs();
        expectFetch("T4 alias", 32'h50, 1'b0);
        setUpdate(32'h90, 1'b0, 32'h123);
        redirectValid = 1'b1; redirectPc = 32'h10;
        applyStimulus();
        clearInputs();
        expectFetch("T4 intact", 32'h10, 1'b1);
        applyStimulus(); expectFetch("T4 target", 32'h40, 1'b0);

        // T5: redirect wins over stall; stall alone holds
        stall = 1'b1; redirectValid = 1'b1; redirectPc = 32'h200;
        applyStimulus();
        redirectValid = 1'b0;
        expectFetch("T5 redirect", 32'h200, 1'b0);
        applyStimulus(); expectFetch("T5 hold", 32'h200, 1'b0);
        clearInputs();

        // T6: reset with a pending update clears everything
        rst = 1'b1;
        setUpdate(32'h200, 1'b1, 32'h300);
        applyStimulus();
        clearInputs();
        expectFetch("T6 reset", 32'h0, 1'b0);
        redirectValid = 1'b1; redirectPc = 32'h10;
        applyStimulus();
        clearInputs();
        expectFetch("T6 empty", 32'h10, 1'b0);
        applyStimulus(); expectFetch("T6 fall", 32'h14, 1'b0);

        // PC + 4 wraps at the top of the address space
        redirectValid = 1'b1; redirectPc = 32'hFFFF_FFFC;
        applyStimulus();
        clearInputs();
        checkOutput("wrap pcPlus4", pcPlus4F0, 32'h0);
        applyStimulus(); expectFetch("wrap next", 32'h0, 1'b0);

        // Randomized traffic over a small address window so slots alias and hit often
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 149) == 0);
            stall         = ($urandom_range(0, 7) == 0);
            redirectValid = ($urandom_range(0, 7) == 0);
            redirectPc    = $urandom_range(0, 63) * 4;
            bUpdateValid  = ($urandom_range(0, 2) != 0);
            bUpdatePc     = $urandom_range(0, 63) * 4;
            bUpdateTaken  = ($urandom_range(0, 2) != 0);
            bUpdateTarget = $urandom_range(0, 63) * 4;
            applyStimulus();
        end
        clearInputs();
        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
